cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/cdb_arbiter.sv | 132 +++++++++++++
 tb/tb_cdb_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Result-bus bundle between the two execution units and the CDB arbiter.
// master = producer/consumer side (execution units, ROB); slave = arbiter.
interface cdb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 3
);
    logic              flush;
    logic              add_valid;
    logic [DATA_W-1:0] add_val;
    logic [TAG_W-1:0]  add_tag;
    logic              mul_valid;
    logic [DATA_W-1:0] mul_val;
    logic [TAG_W-1:0]  mul_tag;
    logic              add_stall;
    logic              mul_stall;
    logic              cdb_valid;
    logic [DATA_W-1:0] cdb_val;
    logic [TAG_W-1:0]  cdb_tag;
    logic              cdb_src;
    logic              overflow;

    modport master (
        output flush, add_valid, add_val, add_tag, mul_valid, mul_val, mul_tag,
        input  add_stall, mul_stall, cdb_valid, cdb_val, cdb_tag, cdb_src, overflow
    );

    modport slave (
        input  flush, add_valid, add_val, add_tag, mul_valid, mul_val, mul_tag,
        output add_stall, mul_stall, cdb_valid, cdb_val, cdb_tag, cdb_src, overflow
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one result FIFO per execution unit (adder, multiplier),
// round-robin grant, registered single-result broadcast per cycle.
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 3,
    parameter int DEPTH  = 2
) (
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {SRC_ADD = 1'b0, SRC_MUL = 1'b1} src_e;

    // Queue index 0 = adder, 1 = multiplier; matches the cdb_src encoding.
    logic [DATA_W-1:0] val_mem [2][DEPTH];
    logic [TAG_W-1:0]  tag_mem [2][DEPTH];
    logic [PW-1:0]     wr_ptr  [2];
    logic [PW-1:0]     rd_ptr  [2];
    logic [CW-1:0]     count   [2];
    src_e              last_grant;

    logic              cdb_valid_q;
    logic [DATA_W-1:0] cdb_val_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic              cdb_src_q;
    logic              overflow_q;

    logic [1:0]        in_valid;
    logic [DATA_W-1:0] in_val [2];
    logic [TAG_W-1:0]  in_tag [2];
    logic [1:0]        nonempty;
    logic [1:0]        full;
    logic [1:0]        grant;
    logic [1:0]        push;
    logic              drop;
    logic [DATA_W-1:0] head_val;
    logic [TAG_W-1:0]  head_tag;

    always_comb begin
        in_valid  = {bus.mul_valid, bus.add_valid};
        in_val[0] = bus.add_val;
        in_val[1] = bus.mul_val;
        in_tag[0] = bus.add_tag;
        in_tag[1] = bus.mul_tag;
        nonempty  = '0;
        full      = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            nonempty[s] = (count[s] != '0);
            full[s]     = (count[s] == FULL);
        end
        // Tie goes to the queue that did not win last time.
        grant[0] = !bus.flush && nonempty[0] && (!nonempty[1] || last_grant == SRC_MUL);
        grant[1] = !bus.flush && nonempty[1] && !grant[0];
        push     = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            push[s] = in_valid[s] && !bus.flush && (!full[s] || grant[s]);
        end
        drop     = !bus.flush && (|(in_valid & full & ~grant));
        head_val = grant[1] ? val_mem[1][rd_ptr[1]] : val_mem[0][rd_ptr[0]];
        head_tag = grant[1] ? tag_mem[1][rd_ptr[1]] : tag_mem[0][rd_ptr[0]];
    end

    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < 2; s++) begin
            if (reset && push[s]) begin
                val_mem[s][wr_ptr[s]] <= in_val[s];
                tag_mem[s][wr_ptr[s]] <= in_tag[s];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < 2; s++) begin
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
                count[s]  <= '0;
            end
            last_grant  <= SRC_MUL;
            cdb_valid_q <= 1'b0;
            cdb_val_q   <= '0;
            cdb_tag_q   <= '0;
            cdb_src_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (bus.flush) begin
                for (int unsigned s = 0; s < 2; s++) begin
                    wr_ptr[s] <= '0;
                    rd_ptr[s] <= '0;
                    count[s]  <= '0;
                end
                cdb_valid_q <= 1'b0;
            end else begin
                for (int unsigned s = 0; s < 2; s++) begin
                    if (push[s]) begin
                        wr_ptr[s] <= wr_ptr[s] + PW'(1);
                    end
                    if (grant[s]) begin
                        rd_ptr[s] <= rd_ptr[s] + PW'(1);
                    end
                    if (push[s] && !grant[s]) begin
                        count[s] <= count[s] + CW'(1);
                    end else if (!push[s] && grant[s]) begin
                        count[s] <= count[s] - CW'(1);
                    end
                end
                cdb_valid_q <= |grant;
                if (|grant) begin
                    cdb_val_q  <= head_val;
                    cdb_tag_q  <= head_tag;
                    cdb_src_q  <= grant[1];
                    last_grant <= grant[1] ? SRC_MUL : SRC_ADD;
                end
            end
        end
    end

    assign bus.add_stall = full[0];
    assign bus.mul_stall = full[1];
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_val   = cdb_val_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_src   = cdb_src_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus queues expected broadcasts,
// a negedge monitor pops and compares every cdb_valid cycle.
module tb_cdb_arbiter;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 3;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic [TAG_W-1:0]  tag;
        logic              src;
    } bcast_t;

    typedef struct {
        int av; int ai; int mv; int mi; int sa; int sm; int ov;
    } bp_row_t;

    bcast_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush     = 1'b0;
        bus.add_valid = 1'b0;
        bus.add_val   = '0;
        bus.add_tag   = '0;
        bus.mul_valid = 1'b0;
        bus.mul_val   = '0;
        bus.mul_tag   = '0;
    endtask

    task automatic drive_add(input logic [DATA_W-1:0] v, input logic [TAG_W-1:0] t);
        bus.add_valid = 1'b1;
        bus.add_val   = v;
        bus.add_tag   = t;
    endtask

    task automatic drive_mul(input logic [DATA_W-1:0] v, input logic [TAG_W-1:0] t);
        bus.mul_valid = 1'b1;
        bus.mul_val   = v;
        bus.mul_tag   = t;
    endtask

    task automatic expect_b(input logic [DATA_W-1:0] v, input logic [TAG_W-1:0] t, input logic s);
        exp_q.push_back({v, t, s});
    endtask

    function automatic logic [63:0] out_word();
        return 64'({bus.cdb_valid, bus.cdb_src, bus.overflow, bus.add_stall,
                    bus.mul_stall, bus.cdb_tag, bus.cdb_val});
    endfunction

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        #1;
        check("reset_outputs", out_word(), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic drain(input string name);
        clear_inputs();
        repeat (5) tick();
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor: every broadcast must match the oldest outstanding expectation.
    initial begin
        bcast_t e;
        forever begin
            @(negedge clk);
            if (bus.cdb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL bcast_unexpected: got val=%0h tag=%0h src=%0b, want none",
                             bus.cdb_val, bus.cdb_tag, bus.cdb_src);
                end else begin
                    e = exp_q.pop_front();
                    check("bcast", 64'({bus.cdb_val, bus.cdb_tag, bus.cdb_src}), 64'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    bp_row_t bp_tab [14] = '{
        '{1, 0, 1, 0, 0, 0, 0},
        '{1, 1, 1, 1, 0, 1, 0},
        '{1, 2, 0, 0, 1, 0, 0},
        '{0, 0, 1, 2, 0, 1, 0},
        '{0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 1, 3, 0, 1, 0},
        '{0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 0, 0, 0, 0, 0},
        '{1, 3, 1, 4, 0, 0, 0},
        '{1, 4, 1, 5, 0, 1, 0},
        '{0, 0, 1, 6, 0, 1, 0},
        '{0, 0, 1, 7, 0, 1, 1},
        '{0, 0, 0, 0, 0, 0, 1},
        '{0, 0, 0, 0, 0, 0, 1}
    };

    initial begin
        bp_row_t r;
        clear_inputs();

        // Single source: 5/tag 2, visible the cycle after the edge following the push.
        do_reset();
        drive_add(32'd5, 3'd2);
        expect_b(32'd5, 3'd2, 1'b0);
        tick();
        clear_inputs();
        check("t1_not_yet", 64'(bus.cdb_valid), 64'd0);
        tick();
        check("t1_valid", 64'(bus.cdb_valid), 64'd1);
        tick();
        check("t1_idle", 64'(bus.cdb_valid), 64'd0);
        check("t1_hold", 64'({bus.cdb_val, bus.cdb_tag}), 64'({32'd5, 3'd2}));
        drain("t1_drain");

        // Tie after reset: adder first, then strict alternation while both stay busy.
        do_reset();
        expect_b(32'd7, 3'd1, 1'b0);  expect_b(32'd9, 3'd3, 1'b1);
        expect_b(32'd17, 3'd4, 1'b0); expect_b(32'd19, 3'd6, 1'b1);
        expect_b(32'd27, 3'd5, 1'b0); expect_b(32'd29, 3'd7, 1'b1);
        drive_add(32'd7, 3'd1);  drive_mul(32'd9, 3'd3);  tick();
        drive_add(32'd17, 3'd4); drive_mul(32'd19, 3'd6); tick();
        drive_add(32'd27, 3'd5); drive_mul(32'd29, 3'd7); tick();
        check("t2_stalls_full", 64'({bus.add_stall, bus.mul_stall}), 64'd3);
        drain("t2_drain");
        check("t2_overflow", 64'(bus.overflow), 64'd0);

        // Wrap: six adder results in order, queue never fills.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_add(32'(32'h30 + i), 3'(i));
            expect_b(32'(32'h30 + i), 3'(i), 1'b0);
            tick();
            check($sformatf("t3_add_stall_%0d", i), 64'(bus.add_stall), 64'd0);
        end
        drain("t3_drain");

        // Flush with both queues full: only results broadcast before the flush edge appear.
        do_reset();
        expect_b(32'd1, 3'd1, 1'b0);
        expect_b(32'd2, 3'd2, 1'b1);
        drive_add(32'd1, 3'd1); drive_mul(32'd2, 3'd2); tick();
        drive_add(32'd3, 3'd3); drive_mul(32'd4, 3'd4); tick();
        drive_add(32'd5, 3'd5); drive_mul(32'd6, 3'd6); tick();
        check("t4_both_full", 64'({bus.add_stall, bus.mul_stall}), 64'd3);
        clear_inputs();
        bus.flush = 1'b1;
        drive_add(32'h99, 3'd7);
        tick();
        clear_inputs();
        check("t4_after_flush", 64'({bus.add_stall, bus.mul_stall, bus.cdb_valid}), 64'd0);
        drain("t4_drain");
        check("t4_overflow", 64'(bus.overflow), 64'd0);

        // Backpressure, then one illegal push into a full, non-popping mul queue (M7 dropped).
        do_reset();
        expect_b(32'h100, 3'd0, 1'b0); expect_b(32'h200, 3'd0, 1'b1);
        expect_b(32'h101, 3'd1, 1'b0); expect_b(32'h201, 3'd1, 1'b1);
        expect_b(32'h102, 3'd2, 1'b0); expect_b(32'h202, 3'd2, 1'b1);
        expect_b(32'h203, 3'd3, 1'b1); expect_b(32'h103, 3'd3, 1'b0);
        expect_b(32'h204, 3'd4, 1'b1); expect_b(32'h104, 3'd4, 1'b0);
        expect_b(32'h205, 3'd5, 1'b1); expect_b(32'h206, 3'd6, 1'b1);
        for (int i = 0; i < 14; i++) begin
            r = bp_tab[i];
            clear_inputs();
            if (r.av != 0) drive_add(32'(32'h100 + r.ai), 3'(r.ai));
            if (r.mv != 0) drive_mul(32'(32'h200 + r.mi), 3'(r.mi));
            tick();
            check($sformatf("t5_stalls_%0d", i), 64'({bus.add_stall, bus.mul_stall}),
                  64'({1'(r.sa), 1'(r.sm)}));
            check($sformatf("t5_overflow_%0d", i), 64'(bus.overflow), 64'(r.ov));
        end
        drain("t5_drain");

        // Async reset while a broadcast is on the bus and a mul result is still queued.
        drive_add(32'h55, 3'd5);
        drive_mul(32'h66, 3'd6);
        tick();
        clear_inputs();
        tick();
        check("t6_valid_before", 64'(bus.cdb_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_outputs", out_word(), 64'd0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        check("t6_quiet_after", out_word(), 64'd0);
        drive_add(32'h77, 3'd6);
        expect_b(32'h77, 3'd6, 1'b0);
        tick();
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
